// File: rtl/dlx_pkg.sv
// -----------------------------------------------------------------------------
// dlx_pkg
// Shared definitions for the DLX execute stage:
//   - WIDTH            datapath width (32 only)
//   - ALU_* constants  4-bit alu_op encodings
//   - mul_state_e      multiplier FSM states
//   - exmem_t          contents of the EX/MEM boundary register
//   - mul_ctrl_t       instruction controls held for the duration of a multiply
//   - is_mul_op()      true for the two multiplier op codes
// -----------------------------------------------------------------------------
package dlx_pkg;

  localparam int WIDTH = 32;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_SLL   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_SLT   = 4'd8;
  localparam logic [3:0] ALU_SLTU  = 4'd9;
  localparam logic [3:0] ALU_SEQ   = 4'd10;
  localparam logic [3:0] ALU_SNE   = 4'd11;
  localparam logic [3:0] ALU_LHI   = 4'd12;
  localparam logic [3:0] ALU_MUL   = 4'd13;
  localparam logic [3:0] ALU_MULHU = 4'd14;
  localparam logic [3:0] ALU_PASSB = 4'd15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mul_state_e;

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] addr;
    logic [WIDTH-1:0] din;
    logic             cs;
    logic             oe;
    logic             we;
    logic [1:0]       load_byte;
    logic             mem_to_reg;
    logic             reg_write;
    logic [4:0]       towrite;
  } exmem_t;

  typedef struct packed {
    logic [WIDTH-1:0] din;
    logic             mem_read;
    logic             mem_write;
    logic             reg_write;
    logic [1:0]       load_byte;
    logic [4:0]       towrite;
    logic             high;      // 1: MULHU, return product[63:32]
  } mul_ctrl_t;

  function automatic logic is_mul_op(input logic [3:0] op);
    return (op == ALU_MUL) || (op == ALU_MULHU);
  endfunction

endpackage

// File: rtl/ex_mul_seq.sv
// -----------------------------------------------------------------------------
// ex_mul_seq
// Iterative shift-add multiplier, one partial product per cycle.
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   start           accept op_a/op_b (only honoured in IDLE)
//   op_a, op_b      multiplicand / multiplier
//   busy            accumulating (MUL_CYCLES cycles)
//   done            one-cycle state in which product is final
//   product         2*WIDTH-bit unsigned product (accumulator)
// Built only when DLX_MUL_EN is defined.
// -----------------------------------------------------------------------------
module ex_mul_seq #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  import dlx_pkg::*;

  localparam int CNT_W = $clog2(MUL_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);

  mul_state_e         state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_d;
  logic [2*WIDTH-1:0] addend_s;

  // Next accumulator value: add the shifted multiplier when this multiplicand bit is set.
  always_comb begin
    addend_s = {{WIDTH{1'b0}}, mplier_q} << cnt_q;
    if (mcand_q[cnt_q]) begin
      acc_d = acc_q + addend_s;
    end else begin
      acc_d = acc_q;
    end
  end

  // Multiplier FSM: IDLE -> BUSY (MUL_CYCLES iterations) -> DONE -> IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            mcand_q  <= op_a;
            mplier_q <= op_b;
            acc_q    <= '0;
            cnt_q    <= '0;
            state_q  <= BUSY;
          end
        end
        BUSY: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy    = (state_q == BUSY);
  assign done    = (state_q == DONE);
  assign product = acc_q;

endmodule

// File: rtl/ex_stage.sv
// -----------------------------------------------------------------------------
// ex_stage
// DLX execute stage: ALU plus the EX/MEM boundary register feeding Mem_stage.
// Optional iterative multiplier (macro DLX_MUL_EN): while a multiply runs the
// front end is stalled and EX/MEM carries bubbles. Without DLX_MUL_EN the MUL
// and MULHU op codes produce 0 in a single cycle and stall_ex is tied low.
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   valid_id, alu_op, use_imm        decoded instruction and operand-B select
//   a, b, imm                        operands (imm already sign-extended)
//   mem_read_id, mem_write_id,
//   reg_write_id, load_byte_id,
//   towrite_id                       memory / write-back controls from decode
//   stall_ex                         combinational hold request to IF/ID
//   valid_ex, addr, din, cs, oe, we,
//   load_byte, MemtoReg_ex,
//   RegWrite_ex, towrite_ex          registered EX/MEM outputs
// -----------------------------------------------------------------------------
module ex_stage #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_id,
  input  logic [3:0]       alu_op,
  input  logic             use_imm,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] imm,
  input  logic             mem_read_id,
  input  logic             mem_write_id,
  input  logic             reg_write_id,
  input  logic [1:0]       load_byte_id,
  input  logic [4:0]       towrite_id,
  output logic             stall_ex,
  output logic             valid_ex,
  output logic [WIDTH-1:0] addr,
  output logic [WIDTH-1:0] din,
  output logic             cs,
  output logic             oe,
  output logic             we,
  output logic [1:0]       load_byte,
  output logic             MemtoReg_ex,
  output logic             RegWrite_ex,
  output logic [4:0]       towrite_ex
);
  import dlx_pkg::*;

  logic [WIDTH-1:0] opb_s;
  logic [4:0]       shamt_s;
  logic [WIDTH-1:0] alu_res_s;
  exmem_t           single_s;
  exmem_t           exmem_d;
  exmem_t           exmem_q;

  assign opb_s   = use_imm ? imm : b;
  assign shamt_s = opb_s[4:0];

  // Single-cycle ALU; multiply op codes yield 0 here and are overridden by the multiplier path.
  always_comb begin
    alu_res_s = '0;
    case (alu_op)
      ALU_ADD:   alu_res_s = a + opb_s;
      ALU_SUB:   alu_res_s = a - opb_s;
      ALU_AND:   alu_res_s = a & opb_s;
      ALU_OR:    alu_res_s = a | opb_s;
      ALU_XOR:   alu_res_s = a ^ opb_s;
      ALU_SLL:   alu_res_s = a << shamt_s;
      ALU_SRL:   alu_res_s = a >> shamt_s;
      ALU_SRA:   alu_res_s = $signed(a) >>> shamt_s;
      ALU_SLT:   alu_res_s = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(opb_s))};
      ALU_SLTU:  alu_res_s = {{(WIDTH-1){1'b0}}, (a < opb_s)};
      ALU_SEQ:   alu_res_s = {{(WIDTH-1){1'b0}}, (a == opb_s)};
      ALU_SNE:   alu_res_s = {{(WIDTH-1){1'b0}}, (a != opb_s)};
      ALU_LHI:   alu_res_s = opb_s << 5'd16;
      ALU_MUL:   alu_res_s = '0;
      ALU_MULHU: alu_res_s = '0;
      ALU_PASSB: alu_res_s = opb_s;
      default:   alu_res_s = '0;
    endcase
  end

  // EX/MEM contents for a single-cycle instruction taken straight from decode.
  always_comb begin
    single_s            = '0;
    single_s.valid      = 1'b1;
    single_s.addr       = alu_res_s;
    single_s.din        = b;
    single_s.cs         = mem_read_id | mem_write_id;
    single_s.oe         = mem_read_id | mem_write_id;
    single_s.we         = mem_write_id;
    single_s.load_byte  = load_byte_id;
    single_s.mem_to_reg = mem_read_id;
    single_s.reg_write  = reg_write_id;
    single_s.towrite    = towrite_id;
  end

`ifdef DLX_MUL_EN
  logic               is_mul_s;
  logic               mul_start_s;
  logic               mul_busy_s;
  logic               mul_done_s;
  logic [2*WIDTH-1:0] mul_product_s;
  mul_ctrl_t          ctrl_d;
  mul_ctrl_t          ctrl_q;
  exmem_t             mul_res_s;

  assign is_mul_s    = is_mul_op(alu_op);
  // Accept only from IDLE; the instruction is re-presented during BUSY and must not restart it.
  assign mul_start_s = valid_id & is_mul_s & ~mul_busy_s & ~mul_done_s;
  assign stall_ex    = valid_id & is_mul_s & ~mul_done_s;

  ex_mul_seq #(
    .WIDTH     (WIDTH),
    .MUL_CYCLES(MUL_CYCLES)
  ) u_mul (
    .clk    (clk),
    .reset  (reset),
    .start  (mul_start_s),
    .op_a   (a),
    .op_b   (opb_s),
    .busy   (mul_busy_s),
    .done   (mul_done_s),
    .product(mul_product_s)
  );

  // Capture the multiply's controls at acceptance; this copy is the one written back.
  always_comb begin
    ctrl_d = ctrl_q;
    if (mul_start_s) begin
      ctrl_d.din       = b;
      ctrl_d.mem_read  = mem_read_id;
      ctrl_d.mem_write = mem_write_id;
      ctrl_d.reg_write = reg_write_id;
      ctrl_d.load_byte = load_byte_id;
      ctrl_d.towrite   = towrite_id;
      ctrl_d.high      = (alu_op == ALU_MULHU);
    end else begin
      ctrl_d = ctrl_q;
    end
  end

  // Held multiply controls.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
    end
  end

  // EX/MEM contents when the multiplier finishes.
  always_comb begin
    mul_res_s            = '0;
    mul_res_s.valid      = 1'b1;
    if (ctrl_q.high) begin
      mul_res_s.addr = mul_product_s[2*WIDTH-1:WIDTH];
    end else begin
      mul_res_s.addr = mul_product_s[WIDTH-1:0];
    end
    mul_res_s.din        = ctrl_q.din;
    mul_res_s.cs         = ctrl_q.mem_read | ctrl_q.mem_write;
    mul_res_s.oe         = ctrl_q.mem_read | ctrl_q.mem_write;
    mul_res_s.we         = ctrl_q.mem_write;
    mul_res_s.load_byte  = ctrl_q.load_byte;
    mul_res_s.mem_to_reg = ctrl_q.mem_read;
    mul_res_s.reg_write  = ctrl_q.reg_write;
    mul_res_s.towrite    = ctrl_q.towrite;
  end

  // EX/MEM next value: DONE wins regardless of valid_id; accept and BUSY send bubbles.
  always_comb begin
    exmem_d = '0;
    if (mul_done_s) begin
      exmem_d = mul_res_s;
    end else if (valid_id && !mul_start_s && !mul_busy_s) begin
      exmem_d = single_s;
    end else begin
      exmem_d = '0;
    end
  end
`else
  assign stall_ex = 1'b0;

  // EX/MEM next value: every valid instruction completes in one cycle.
  always_comb begin
    exmem_d = '0;
    if (valid_id) begin
      exmem_d = single_s;
    end else begin
      exmem_d = '0;
    end
  end
`endif

  // EX/MEM boundary register.
  always_ff @(posedge clk) begin
    if (reset) begin
      exmem_q <= '0;
    end else begin
      exmem_q <= exmem_d;
    end
  end

  assign valid_ex    = exmem_q.valid;
  assign addr        = exmem_q.addr;
  assign din         = exmem_q.din;
  assign cs          = exmem_q.cs;
  assign oe          = exmem_q.oe;
  assign we          = exmem_q.we;
  assign load_byte   = exmem_q.load_byte;
  assign MemtoReg_ex = exmem_q.mem_to_reg;
  assign RegWrite_ex = exmem_q.reg_write;
  assign towrite_ex  = exmem_q.towrite;

endmodule

// File: tb/tb_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_ex_stage
// Directed vectors with hand-computed results. Each issued instruction pushes
// its expected EX/MEM contents and arrival cycle into a queue; a negedge
// monitor pops and compares whenever valid_ex is high and otherwise checks
// that EX/MEM holds an all-zero bubble. Works with and without DLX_MUL_EN.
// -----------------------------------------------------------------------------
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_id;
  logic [3:0]  alu_op;
  logic        use_imm;
  logic [31:0] a, b, imm;
  logic        mem_read_id, mem_write_id, reg_write_id;
  logic [1:0]  load_byte_id;
  logic [4:0]  towrite_id;
  logic        stall_ex, valid_ex, cs, oe, we, MemtoReg_ex, RegWrite_ex;
  logic [31:0] addr, din;
  logic [1:0]  load_byte;
  logic [4:0]  towrite_ex;

  ex_stage #(.WIDTH(32), .MUL_CYCLES(32)) dut (
    .clk(clk), .reset(reset), .valid_id(valid_id), .alu_op(alu_op),
    .use_imm(use_imm), .a(a), .b(b), .imm(imm),
    .mem_read_id(mem_read_id), .mem_write_id(mem_write_id),
    .reg_write_id(reg_write_id), .load_byte_id(load_byte_id),
    .towrite_id(towrite_id), .stall_ex(stall_ex), .valid_ex(valid_ex),
    .addr(addr), .din(din), .cs(cs), .oe(oe), .we(we), .load_byte(load_byte),
    .MemtoReg_ex(MemtoReg_ex), .RegWrite_ex(RegWrite_ex), .towrite_ex(towrite_ex)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [31:0] din;
    logic        cs;
    logic        oe;
    logic        we;
    logic [1:0]  lb;
    logic        m2r;
    logic        rw;
    logic [4:0]  tw;
  } obs_t;

  typedef struct {
    int   cyc;
    obs_t val;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  obs_t obs_s;
  int   errors = 0;
  int   checks = 0;
  bit   mon_en = 1'b0;

  assign obs_s = {valid_ex, addr, din, cs, oe, we, load_byte, MemtoReg_ex, RegWrite_ex, towrite_ex};

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
    end
  endtask

  // Monitor: pop on every valid result, otherwise require an all-zero bubble.
  always @(negedge clk) begin
    if (mon_en) begin
      if (valid_ex === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid at cycle %0d: got %h, expected no result", cyc, obs_s);
        end else begin
          mon_e = sb.pop_front();
          chk("latency", 80'(cyc), 80'(mon_e.cyc));
          chk("payload", 80'(obs_s), 80'(mon_e.val));
        end
      end else begin
        chk("bubble", 80'(obs_s), 80'd0);
      end
    end
  end

  // Present one instruction, push its expected result, check stall_ex each cycle it is held.
  task automatic issue(input logic [3:0] op, input logic [31:0] ia, input logic [31:0] ib,
                       input logic [31:0] iimm, input logic ui, input logic mr, input logic mw,
                       input logic rw, input logic [1:0] lb, input logic [4:0] tw,
                       input logic [31:0] eaddr);
    exp_t e;
    int   lat;
    bit   ismul;
    ismul = (op == 4'd13) || (op == 4'd14);
    valid_id = 1'b1; alu_op = op; a = ia; b = ib; imm = iimm; use_imm = ui;
    mem_read_id = mr; mem_write_id = mw; reg_write_id = rw; load_byte_id = lb; towrite_id = tw;
    e.val = {1'b1, eaddr, ib, mr | mw, mr | mw, mw, lb, mr, rw, tw};
`ifdef DLX_MUL_EN
    lat = ismul ? 34 : 1;
`else
    lat = 1;
    if (ismul) e.val.addr = 32'h0;
`endif
    e.cyc = cyc + lat;
    sb.push_back(e);
    for (int k = 0; k < lat; k++) begin
      @(negedge clk);
      chk("stall_ex", 80'(stall_ex), (k < lat - 1) ? 80'd1 : 80'd0);
      @(posedge clk); #1;
    end
  endtask

  // One cycle with valid_id low but noisy operands and controls.
  task automatic idle_cycle();
    valid_id = 1'b0; alu_op = 4'd0; a = 32'hFFFF_FFFF; b = 32'h1234_5678; imm = 32'h1;
    use_imm = 1'b0; mem_read_id = 1'b1; mem_write_id = 1'b1; reg_write_id = 1'b1;
    load_byte_id = 2'b11; towrite_id = 5'd31;
    @(negedge clk);
    chk("idle_stall", 80'(stall_ex), 80'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; valid_id = 1'b0; alu_op = 4'd0; use_imm = 1'b0;
    a = 32'h0; b = 32'h0; imm = 32'h0;
    mem_read_id = 1'b0; mem_write_id = 1'b0; reg_write_id = 1'b0;
    load_byte_id = 2'b00; towrite_id = 5'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", 80'(obs_s), 80'd0);
    chk("reset_stall", 80'(stall_ex), 80'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    mon_en = 1'b1;

    //     op      a             b             imm           ui    mr    mw    rw    lb     tw     expected addr
    issue(4'd0,  32'h7FFF_FFFF, 32'h0000_0001, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 5'd5,  32'h8000_0000);
    issue(4'd7,  32'hF000_0000, 32'h0000_0055, 32'h4,        1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 5'd6,  32'hFF00_0000);
    issue(4'd8,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 5'd7,  32'h0000_0001);
    issue(4'd9,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 5'd8,  32'h0000_0000);
    issue(4'd0,  32'h0000_0100, 32'h0000_DEAD, 32'h8,        1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 5'd0,  32'h0000_0108);
    issue(4'd0,  32'h0000_0200, 32'h0000_0011, 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 5'd9,  32'h0000_01FC);
    issue(4'd1,  32'h0000_0005, 32'h0000_0007, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 5'd10, 32'hFFFF_FFFE);
    issue(4'd2,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 5'd11, 32'hF000_F000);
    issue(4'd3,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 5'd12, 32'hFFF0_FFF0);
    issue(4'd4,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 5'd13, 32'h0FF0_0FF0);
    issue(4'd5,  32'h0000_0001, 32'h0000_0023, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 5'd14, 32'h0000_0008);
    issue(4'd6,  32'h8000_0000, 32'h0000_0004, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 5'd15, 32'h0800_0000);
    issue(4'd10, 32'h0000_0005, 32'h0000_0009, 32'h5,        1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 5'd16, 32'h0000_0001);
    issue(4'd11, 32'h0000_0005, 32'h0000_0006, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 5'd17, 32'h0000_0001);
    issue(4'd12, 32'h0000_FFFF, 32'h0000_0003, 32'h1234,     1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 5'd18, 32'h1234_0000);
    issue(4'd15, 32'h1111_1111, 32'h0000_ABCD, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 5'd19, 32'h0000_ABCD);
    idle_cycle();

    // Multiply with immediate operand, then a single-cycle op right after DONE.
    issue(4'd13, 32'h1234_5678, 32'h0000_0077, 32'h10,       1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 5'd20, 32'h2345_6780);
    issue(4'd0,  32'h0000_0003, 32'h0000_0004, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 5'd21, 32'h0000_0007);
    // Back-to-back multiplies.
    issue(4'd14, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 5'd22, 32'hFFFF_FFFE);
    issue(4'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 5'd23, 32'h0000_0001);

`ifdef DLX_MUL_EN
    // Reset during iteration 10, then the still-presented multiply restarts.
    valid_id = 1'b1; alu_op = 4'd13; a = 32'h0001_0003; b = 32'h0000_0007; imm = 32'h0;
    use_imm = 1'b0; mem_read_id = 1'b0; mem_write_id = 1'b0; reg_write_id = 1'b1;
    load_byte_id = 2'b00; towrite_id = 5'd24;
    repeat (11) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_mid_valid", 80'(valid_ex), 80'd0);
    chk("rst_mid_addr", 80'(addr), 80'd0);
    issue(4'd13, 32'h0001_0003, 32'h0000_0007, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 5'd24, 32'h0007_0015);
`else
    // Reset while an instruction is presented clears EX/MEM.
    valid_id = 1'b1; alu_op = 4'd0; a = 32'h5; b = 32'h6; use_imm = 1'b0;
    reg_write_id = 1'b1; towrite_id = 5'd3;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_valid", 80'(valid_ex), 80'd0);
    chk("rst_addr", 80'(addr), 80'd0);
`endif
    issue(4'd0,  32'h0000_0010, 32'h0000_0020, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 5'd25, 32'h0000_0030);
    idle_cycle();
    idle_cycle();

    for (int i = 0; i < 5 && sb.size() != 0; i++) @(posedge clk);
    chk("drain", 80'(sb.size()), 80'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
# ex_stage

DLX execute stage. Sits between decode and `Mem_stage`: it takes decoded operands and control bits, computes the ALU result, and registers the result plus memory and write-back controls into the EX/MEM boundary that drives the memory stage's `addr`, `din`, `we`, `load_byte`, `MemtoReg_ex`, `RegWrite_ex` and `towrite_ex`. It also contains an iterative 32-cycle shift-add multiplier. While a multiply is in progress the block stalls the front end and sends bubbles downstream.

## Interface
Parameters:
- `WIDTH`, default 32: datapath width. Only 32 is supported.
- `MUL_CYCLES`, default 32: number of multiplier iterations. Must equal `WIDTH`.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `valid_id`  in  1  decode presents a valid instruction.
- `alu_op`  in  4  operation code (see Operation).
- `use_imm`  in  1  1 selects `imm` as operand B; 0 selects `b`.
- `a`, `b`, `imm`  in  32 each  operand A, operand B, sign-extended immediate.
- `mem_read_id`, `mem_write_id`, `reg_write_id`  in  1 each  load, store, write-back flags.
- `load_byte_id`  in  2  load-width code; passed through unchanged.
- `towrite_id`  in  5  destination register.
- `stall_ex`  out  1  combinational; 1 tells IF/ID to hold the current instruction.
- `valid_ex`  out  1  registered; EX/MEM holds a real instruction.
- `addr`  out  32  registered ALU result (memory address or result).
- `din`  out  32  registered store data (`b`).
- `cs`, `oe`, `we`  out  1 each  registered memory controls.
- `load_byte`  out  2  registered copy of `load_byte_id`.
- `MemtoReg_ex`, `RegWrite_ex`  out  1 each  registered write-back controls.
- `towrite_ex`  out  5  registered destination register.

## Operation
- `opB = use_imm ? imm : b`. All arithmetic is modulo 2^32; overflow is ignored.
- ALU op codes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SLL, 6 SRL, 7 SRA. Shift amount is `opB[4:0]`.
  - 8 SLT (signed), 9 SLTU (unsigned), 10 SEQ, 11 SNE. Set ops produce 32'h0 or 32'h1.
  - 12 LHI: result is `opB << 16`.
  - 13 MUL: low 32 bits of the product.
  - 14 MULHU: high 32 bits of the unsigned 64-bit product.
  - 15 PASSB: result is `opB`.
- Memory controls: `cs = oe = mem_read_id | mem_write_id`; `we = mem_write_id`; `MemtoReg_ex = mem_read_id`.
- Bubble: every registered output is 0 (`valid_ex`, `cs`, `oe`, `we`, `RegWrite_ex`, `MemtoReg_ex`, `addr`, `din`, `towrite_ex`, `load_byte`).
- Multiplier FSM:
  - IDLE: on `valid_id` with op 13 or 14, latch `a` and `opB`, clear the 64-bit accumulator, set `cnt = 0`, go to BUSY. The EX/MEM register loads a bubble.
  - BUSY: each cycle, if `mcand[cnt]` is set, add `mplier << cnt` to the accumulator; increment `cnt`. When `cnt == MUL_CYCLES-1`, go to DONE. EX/MEM loads bubbles.
  - DONE: EX/MEM captures accumulator[31:0] (MUL) or [63:32] (MULHU) together with the instruction's controls; go to IDLE.
- `stall_ex = valid_id & is_mul & (state != DONE)`.
- In BUSY the upstream stages keep presenting the same multiply instruction; the latched copy is authoritative.
- `valid_id = 0` loads a bubble. This applies in IDLE; in BUSY and DONE it does not abort the multiply.

## Timing
- Reset: state = IDLE, `cnt = 0`, accumulator = 0, all registered outputs 0. `stall_ex` follows its equation, so it is 0 when `valid_id = 0`.
- Single-cycle ops: inputs at cycle T appear on the outputs at T+1; `stall_ex = 0`.
- Multiply accepted at cycle T:
  - `stall_ex` is high T..T+32.
  - BUSY occupies T+1..T+32; DONE is at T+33.
  - The result is valid on `addr` at T+34.
  - EX/MEM holds bubbles T+1..T+33.
- Back-to-back multiplies: the second one is seen in IDLE at T+34 and starts a new 33-cycle stall.
- Reset asserted in BUSY or DONE: the next cycle is IDLE and the partial product is discarded. A multiply still presented restarts from IDLE.
- A single-cycle op immediately after DONE proceeds with no extra bubble.

## Configuration
- Macro `DLX_MUL_EN`.
- Defined: multiplier FSM present; op codes 13 and 14 behave as above.
- Undefined: no FSM or accumulator logic is built; `stall_ex` is tied to 0; op codes 13 and 14 produce result 32'h0 in one cycle with their controls passed through.

## Structure
- Package `dlx_pkg`:
  - `alu_op` encoding constants (`ALU_ADD` .. `ALU_PASSB`).
  - FSM state enum `{IDLE, BUSY, DONE}`.
  - `WIDTH`.
- One sub-module, `ex_mul_seq`:
  - Inputs: `start`, operands.
  - Outputs: `busy`, `done`, 64-bit product.
  - Instantiated only under `DLX_MUL_EN`.

## Test plan
- ADD with `a = 32'h7FFFFFFF`, `b = 1`, `use_imm = 0` → next cycle `addr = 32'h80000000`, `RegWrite_ex` follows `reg_write_id`, `stall_ex = 0`.
- SRA with `a = 32'hF0000000`, `imm = 4`, `use_imm = 1` → `addr = 32'hFF000000`. SLT(-1, 1) → 1; SLTU(-1, 1) → 0.
- Store with `mem_write_id = 1`, `a = 32'h100`, `imm = 8`, `b = 32'hDEAD` → `addr = 32'h108`, `din = 32'hDEAD`, `we = cs = oe = 1`, `MemtoReg_ex = 0`.
- MUL 32'h12345678 × 32'h10 at T → `stall_ex` high for exactly 33 cycles, bubbles T+1..T+33, `addr = 32'h23456780` at T+34. MULHU 32'hFFFFFFFF × 32'hFFFFFFFF → `addr = 32'hFFFFFFFE`.
- Reset pulsed at iteration 10 of a multiply → all outputs 0 the next cycle; the re-presented multiply completes 33 cycles after re-acceptance with the correct product.
- Build without `DLX_MUL_EN` → MUL yields `addr = 0` one cycle later and `stall_ex` never asserts.
